// File: rtl/door_pkg.sv
// Shared door-control definitions: channel map and conditioner defaults.
// The door FSM and the top-level pin mapping use the same constants.
package door_pkg;

    localparam int N_CH   = 4;

    // Bit positions within raw_in / sens_out
    localparam int CH_SEN = 0;   // presence sensor
    localparam int CH_SE  = 1;   // external / safety sensor
    localparam int CH_LA  = 2;   // open limit switch
    localparam int CH_LC  = 3;   // closed limit switch

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 16;

endpackage

// File: rtl/door_sensor_conditioner_if.sv
// Signal bundle between the raw door pads and the conditioned FSM inputs.
// master drives the raw side (pads / bench), slave is the conditioner.
interface door_sensor_conditioner_if;
    import door_pkg::*;

    logic            ena;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] sens_out;
    logic [N_CH-1:0] rise_p;
    logic [N_CH-1:0] fall_p;
    logic            lim_fault;

    modport master (
        output ena, raw_in,
        input  sens_out, rise_p, fall_p, lim_fault
    );

    modport slave (
        input  ena, raw_in,
        output sens_out, rise_p, fall_p, lim_fault
    );

endinterface

// File: rtl/door_debounce_ch.sv
// One door input channel: synchroniser chain, debounce counter,
// accepted (stable) level and registered one-cycle edge pulses.
module door_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic stable,
    output logic rise_p,
    output logic fall_p
);

    localparam int                CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("door_debounce_ch: SYNC_STAGES must be at least 2");
        end
        if (DEB_CYCLES < 2) begin : g_bad_deb
            $error("door_debounce_ch: DEB_CYCLES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser shifts every cycle, regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce: accept a new level only after DEB_CYCLES consecutive enabled
    // edges disagreeing with the stable level; any bounce back restarts the count.
    // Pulses are registered alongside stable so they coincide with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
        end else begin
            rise_p <= 1'b0;
            fall_p <= 1'b0;
            if (ena) begin
                if (sync == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    stable <= sync;
                    cnt    <= '0;
                    rise_p <= sync;
                    fall_p <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/door_sensor_conditioner.sv
// Door input stage: conditions Sen, SE, LA and LC into clean levels and
// edge pulses for the door FSM, and flags both limit switches active at once.
module door_sensor_conditioner
    import door_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    door_sensor_conditioner_if.slave    bus
);

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            door_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES)
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (bus.ena),
                .raw    (bus.raw_in[i]),
                .stable (stable[i]),
                .rise_p (rise[i]),
                .fall_p (fall[i])
            );
        end
    endgenerate

    assign bus.sens_out  = stable;
    assign bus.rise_p    = rise;
    assign bus.fall_p    = fall;
    // Open and closed limits together is physically impossible; report, don't mask
    assign bus.lim_fault = stable[CH_LA] & stable[CH_LC];

endmodule

// File: tb/tb_door_sensor_conditioner.sv
// Bench for door_sensor_conditioner: directed stimulus pushes the expected
// pulse events (cycle, pulses, levels, fault) into a queue; a monitor pops
// and compares whenever the DUT emits a rise or fall pulse.
module tb_door_sensor_conditioner;
    import door_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] sens;
        logic       lim;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    door_sensor_conditioner_if bus();

    door_sensor_conditioner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count active edges; at a negedge cyc equals the number of edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] s, input logic l);
        ev_t e;
        e.cyc = at; e.rise = r; e.fall = f; e.sens = s; e.lim = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the oldest expectation; an expectation
    // whose cycle has passed without a pulse is reported as missed.
    always @(negedge clk) begin
        if ((bus.rise_p | bus.fall_p) != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise=%b fall=%b sens=%b at cycle %0d, expected none",
                         bus.rise_p, bus.fall_p, bus.sens_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("pulse_outputs", {19'd0, bus.rise_p, bus.fall_p, bus.sens_out, bus.lim_fault},
                    {19'd0, mon_e.rise, mon_e.fall, mon_e.sens, mon_e.lim});
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: nothing at cycle %0d, expected rise=%b fall=%b at cycle %0d",
                     cyc, mon_e.rise, mon_e.fall, mon_e.cyc);
        end
    end

    int bl [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int bn [10] = '{1, 1, 3, 3, 15, 1, 15, 3, 1, 15};

    initial begin
        int t;
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.raw_in  = 4'b1111;

        // Reset held with all inputs high
        wait_cyc(3);
        chk("reset_hold", {bus.sens_out, bus.rise_p, bus.fall_p, bus.lim_fault}, 13'd0);
        rst_n = 1'b1;
        chk("reset_release", {bus.sens_out, bus.rise_p, bus.fall_p, bus.lim_fault}, 13'd0);

        // Reset again with cnt=10 mid-debounce; the count must restart from zero
        wait_cyc(12);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_count", {bus.sens_out, bus.rise_p, bus.fall_p, bus.lim_fault}, 13'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        t = cyc;
        // All four rise together; LA and LC together raise lim_fault
        expect_ev(t + 18, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        wait_cyc(22);
        chk("all_high_level", bus.sens_out, 4'b1111);

        // Asynchronous clear with outputs high
        rst_n = 1'b0;
        #1;
        chk("async_clear_sens", bus.sens_out, 4'b0000);
        chk("async_clear_lim", bus.lim_fault, 1'b0);
        @(negedge clk);
        bus.raw_in = 4'b0000;
        rst_n      = 1'b1;
        wait_cyc(20);

        // Clean step on Sen, rise then fall
        bus.raw_in[CH_SEN] = 1'b1;
        t = cyc;
        expect_ev(t + 18, 4'b0001, 4'b0000, 4'b0001, 1'b0);
        wait_cyc(17);
        chk("sen_not_early", bus.sens_out, 4'b0000);
        wait_cyc(5);
        bus.raw_in[CH_SEN] = 1'b0;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        wait_cyc(22);

        // Bounce on LA: bursts up to 15 cycles must be rejected
        for (int i = 0; i < 10; i++) begin
            bus.raw_in[CH_LA] = bl[i][0];
            wait_cyc(bn[i]);
        end
        chk("bounce_rejected", bus.sens_out, 4'b0000);
        bus.raw_in[CH_LA] = 1'b1;
        t = cyc;
        expect_ev(t + 18, 4'b0100, 4'b0000, 4'b0100, 1'b0);
        wait_cyc(22);
        bus.raw_in[CH_LA] = 1'b0;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        wait_cyc(22);

        // Limit fault: LA and LC together, then release LC
        bus.raw_in[CH_LC:CH_LA] = 2'b11;
        t = cyc;
        expect_ev(t + 18, 4'b1100, 4'b0000, 4'b1100, 1'b1);
        wait_cyc(22);
        chk("lim_fault_level", bus.lim_fault, 1'b1);
        bus.raw_in[CH_LC] = 1'b0;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b1000, 4'b0100, 1'b0);
        wait_cyc(22);
        bus.raw_in[CH_LA] = 1'b0;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        wait_cyc(22);

        // Enable freeze on LC: 8 enabled edges, 20 frozen, 8 more
        bus.raw_in[CH_LC] = 1'b1;
        t = cyc;
        wait_cyc(10);
        bus.ena = 1'b0;
        wait_cyc(20);
        chk("freeze_holds", bus.sens_out, 4'b0000);
        bus.ena = 1'b1;
        expect_ev(t + 38, 4'b1000, 4'b0000, 4'b1000, 1'b0);
        wait_cyc(7);
        chk("freeze_not_early", bus.sens_out, 4'b0000);
        wait_cyc(5);
        bus.raw_in[CH_LC] = 1'b0;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b1000, 4'b0000, 1'b0);
        wait_cyc(22);

        // Independence: SE, LA, LC step while Sen toggles every cycle
        bus.raw_in = 4'b1111;
        t = cyc;
        expect_ev(t + 18, 4'b1110, 4'b0000, 4'b1110, 1'b1);
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            bus.raw_in[CH_SEN] = ~bus.raw_in[CH_SEN];
        end
        bus.raw_in[CH_SEN] = 1'b0;
        chk("indep_level", bus.sens_out, 4'b1110);
        wait_cyc(2);
        bus.raw_in = 4'b0000;
        t = cyc;
        expect_ev(t + 18, 4'b0000, 4'b1110, 4'b0000, 1'b0);
        wait_cyc(24);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
